// File: rtl/register_file_1w_wide_1r_narrow_burst_pkg.sv
// Shared types and helpers for the wide-write / narrow-read register file.
// Contents: rf_state_e (read FSM states) and lane_of() (lane slice of a read address).
// Optional feature macro used by the top: RF_READ_BYPASS_EN.
package rf_wide_narrow_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rf_state_e;

  // Lane select is the low lane_w bits of a {row, lane} read address.
  function automatic int unsigned lane_of(input int unsigned addr, input int unsigned lane_w);
    return addr & ((32'd1 << lane_w) - 32'd1);
  endfunction

endpackage

// File: rtl/register_file_1w_wide_1r_narrow_burst_if.sv
// Bus bundle for the register file: narrow read request/response plus wide byte-enabled write.
// master: drives ReadEnable/ReadBurst/ReadAddr and the Write* signals, receives ReadReady/ReadData/ReadValid.
// slave : the register file side (mirror of master).
interface register_file_1w_wide_1r_narrow_burst_if #(
  parameter int WADDR_WIDTH = 5,
  parameter int WDATA_WIDTH = 64,
  parameter int RDATA_WIDTH = 32,
  parameter int N_LANES     = WDATA_WIDTH / RDATA_WIDTH,
  parameter int LANE_WIDTH  = $clog2(N_LANES),
  parameter int RADDR_WIDTH = WADDR_WIDTH + LANE_WIDTH
);
  logic                     ReadEnable;
  logic                     ReadBurst;
  logic [RADDR_WIDTH-1:0]   ReadAddr;
  logic                     ReadReady;
  logic [RDATA_WIDTH-1:0]   ReadData;
  logic                     ReadValid;
  logic                     WriteEnable;
  logic [WADDR_WIDTH-1:0]   WriteAddr;
  logic [WDATA_WIDTH/8-1:0] WriteBE;
  logic [WDATA_WIDTH-1:0]   WriteData;

  modport master (
    output ReadEnable, ReadBurst, ReadAddr, WriteEnable, WriteAddr, WriteBE, WriteData,
    input  ReadReady, ReadData, ReadValid
  );

  modport slave (
    input  ReadEnable, ReadBurst, ReadAddr, WriteEnable, WriteAddr, WriteBE, WriteData,
    output ReadReady, ReadData, ReadValid
  );
endinterface

// File: rtl/register_file_1w_wide_1r_narrow_burst_array.sv
// Flop storage of W_N_ROWS rows x WDATA_WIDTH bits, byte-enabled write, combinational lane read.
// Ports: clk; i_we/i_waddr/i_wbe/i_wdata write port; i_rrow/i_rlane select; o_rdata lane data.
// Storage is deliberately not reset; writes land at every posedge with i_we regardless of reset.
module rf_wide_narrow_array #(
  parameter int WADDR_WIDTH = 5,
  parameter int WDATA_WIDTH = 64,
  parameter int RDATA_WIDTH = 32,
  parameter int N_LANES     = WDATA_WIDTH / RDATA_WIDTH,
  parameter int LANE_WIDTH  = $clog2(N_LANES)
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [WADDR_WIDTH-1:0]   i_waddr,
  input  logic [WDATA_WIDTH/8-1:0] i_wbe,
  input  logic [WDATA_WIDTH-1:0]   i_wdata,
  input  logic [WADDR_WIDTH-1:0]   i_rrow,
  input  logic [LANE_WIDTH-1:0]    i_rlane,
  output logic [RDATA_WIDTH-1:0]   o_rdata
);
  localparam int W_N_ROWS = 2 ** WADDR_WIDTH;
  localparam int N_BYTES  = WDATA_WIDTH / 8;

  logic [WDATA_WIDTH-1:0] r_mem [W_N_ROWS];
  logic [WDATA_WIDTH-1:0] w_row_dat;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < N_BYTES; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign w_row_dat = r_mem[i_rrow];

  always_comb begin
    o_rdata = '0;
    for (int l = 0; l < N_LANES; l++) begin
      if (i_rlane == LANE_WIDTH'(l)) begin
        o_rdata = w_row_dat[l*RDATA_WIDTH +: RDATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/register_file_1w_wide_1r_narrow_burst.sv
// Register file with one wide byte-enabled write port and one narrow registered read port with burst.
// Ports: clk, rst_n (sync, active-low), bus (slave modport: Read*/Write* signals).
// Read latency 1; ReadReady low while a burst streams, high again on its last beat.
// Optional: RF_READ_BYPASS_EN merges same-cycle write bytes into the returned lane.
module register_file_1w_wide_1r_narrow_burst
  import rf_wide_narrow_pkg::*;
#(
  parameter int WADDR_WIDTH = 5,
  parameter int WDATA_WIDTH = 64,
  parameter int RDATA_WIDTH = 32,
  parameter int N_LANES     = WDATA_WIDTH / RDATA_WIDTH,
  parameter int LANE_WIDTH  = $clog2(N_LANES),
  parameter int RADDR_WIDTH = WADDR_WIDTH + LANE_WIDTH,
  parameter int W_N_ROWS    = 2 ** WADDR_WIDTH
) (
  input logic clk,
  input logic rst_n,
  register_file_1w_wide_1r_narrow_burst_if.slave bus
);
  localparam int LANE_BYTES = RDATA_WIDTH / 8;

  if (N_LANES < 2 || (N_LANES & (N_LANES - 1)) != 0) begin : g_bad_lanes
    $error("N_LANES must be a power of two >= 2");
  end
  if (WDATA_WIDTH != N_LANES * RDATA_WIDTH) begin : g_bad_wdata
    $error("WDATA_WIDTH must equal N_LANES*RDATA_WIDTH");
  end
  if (RDATA_WIDTH % 8 != 0) begin : g_bad_rdata
    $error("RDATA_WIDTH must be a multiple of 8");
  end

  rf_state_e              r_state;
  rf_state_e              w_state_nxt;
  logic [WADDR_WIDTH-1:0] r_row;
  logic [LANE_WIDTH-1:0]  r_lane;
  logic [LANE_WIDTH-1:0]  r_beat;
  logic [RDATA_WIDTH-1:0] r_rdata;
  logic                   r_rvalid;

  logic                   w_ready;
  logic                   w_issue;
  logic [WADDR_WIDTH-1:0] w_req_row;
  logic [LANE_WIDTH-1:0]  w_req_lane;
  logic [WADDR_WIDTH-1:0] w_sel_row;
  logic [LANE_WIDTH-1:0]  w_sel_lane;
  logic [WADDR_WIDTH-1:0] w_wr_row;
  logic [RDATA_WIDTH-1:0] w_arr_dat;
  logic [RDATA_WIDTH-1:0] w_rd_dat;

  // A single-row file ignores row address bits entirely.
  assign w_req_row  = (W_N_ROWS == 1) ? '0 : bus.ReadAddr[RADDR_WIDTH-1:LANE_WIDTH];
  assign w_wr_row   = (W_N_ROWS == 1) ? '0 : bus.WriteAddr;
  assign w_req_lane = LANE_WIDTH'(lane_of(32'(bus.ReadAddr), 32'(LANE_WIDTH)));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state. r_beat counts beats already issued, so N_LANES-1 means this is the last one.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.ReadEnable && bus.ReadBurst) w_state_nxt = BURST;
      BURST:   if (r_beat == LANE_WIDTH'(N_LANES - 1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. In IDLE the array is addressed straight from the request so beat 0 costs no extra cycle.
  always_comb begin
    w_ready    = 1'b0;
    w_issue    = 1'b0;
    w_sel_row  = r_row;
    w_sel_lane = r_lane;
    case (r_state)
      IDLE: begin
        w_ready    = 1'b1;
        w_issue    = bus.ReadEnable;
        w_sel_row  = w_req_row;
        w_sel_lane = w_req_lane;
      end
      BURST:   w_issue = 1'b1;
      default: ;
    endcase
  end

  // Burst bookkeeping; the lane counter wraps within the row by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row  <= '0;
      r_lane <= '0;
      r_beat <= '0;
    end else if (r_state == IDLE) begin
      if (bus.ReadEnable && bus.ReadBurst) begin
        r_row  <= w_req_row;
        r_lane <= w_req_lane + 1'b1;
        r_beat <= LANE_WIDTH'(1);
      end
    end else begin
      r_lane <= r_lane + 1'b1;
      r_beat <= r_beat + 1'b1;
    end
  end

  rf_wide_narrow_array #(
    .WADDR_WIDTH (WADDR_WIDTH),
    .WDATA_WIDTH (WDATA_WIDTH),
    .RDATA_WIDTH (RDATA_WIDTH),
    .N_LANES     (N_LANES),
    .LANE_WIDTH  (LANE_WIDTH)
  ) u_array (
    .clk     (clk),
    .i_we    (bus.WriteEnable),
    .i_waddr (w_wr_row),
    .i_wbe   (bus.WriteBE),
    .i_wdata (bus.WriteData),
    .i_rrow  (w_sel_row),
    .i_rlane (w_sel_lane),
    .o_rdata (w_arr_dat)
  );

  // Without the bypass the array value is pre-write data for a same-cycle collision.
  always_comb begin
    w_rd_dat = w_arr_dat;
`ifdef RF_READ_BYPASS_EN
    if (bus.WriteEnable && (w_wr_row == w_sel_row)) begin
      for (int l = 0; l < N_LANES; l++) begin
        if (w_sel_lane == LANE_WIDTH'(l)) begin
          for (int k = 0; k < LANE_BYTES; k++) begin
            if (bus.WriteBE[l*LANE_BYTES + k]) begin
              w_rd_dat[8*k +: 8] = bus.WriteData[(l*LANE_BYTES + k)*8 +: 8];
            end
          end
        end
      end
    end
`endif
  end

  // Output register: data holds when nothing is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_issue;
      if (w_issue) r_rdata <= w_rd_dat;
    end
  end

  assign bus.ReadReady = w_ready;
  assign bus.ReadValid = r_rvalid;
  assign bus.ReadData  = r_rdata;

endmodule

// File: tb/tb_register_file_1w_wide_1r_narrow_burst.sv
// Bench for two register file configurations: A (64->32, 2 lanes, 32 rows) and B (128->32, 4 lanes, 8 rows).
// A queue-of-lane-addresses reference model predicts ReadReady/ReadValid/ReadData every cycle.
// Directed cases first, then randomized traffic with occasional resets.
module tb_register_file_1w_wide_1r_narrow_burst;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  register_file_1w_wide_1r_narrow_burst_if #(.WADDR_WIDTH(5), .WDATA_WIDTH(64),  .RDATA_WIDTH(32)) bus_a ();
  register_file_1w_wide_1r_narrow_burst_if #(.WADDR_WIDTH(3), .WDATA_WIDTH(128), .RDATA_WIDTH(32)) bus_b ();

  register_file_1w_wide_1r_narrow_burst #(.WADDR_WIDTH(5), .WDATA_WIDTH(64), .RDATA_WIDTH(32)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a)
  );
  register_file_1w_wide_1r_narrow_burst #(.WADDR_WIDTH(3), .WDATA_WIDTH(128), .RDATA_WIDTH(32)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
  );

  // Per-DUT drive values (index 0 = A, 1 = B), sized for the widest config.
  logic         d_re    [2];
  logic         d_rb    [2];
  logic [7:0]   d_raddr [2];
  logic         d_we    [2];
  logic [7:0]   d_waddr [2];
  logic [15:0]  d_wbe   [2];
  logic [127:0] d_wdata [2];

  assign bus_a.ReadEnable  = d_re[0];
  assign bus_a.ReadBurst   = d_rb[0];
  assign bus_a.ReadAddr    = d_raddr[0][5:0];
  assign bus_a.WriteEnable = d_we[0];
  assign bus_a.WriteAddr   = d_waddr[0][4:0];
  assign bus_a.WriteBE     = d_wbe[0][7:0];
  assign bus_a.WriteData   = d_wdata[0][63:0];

  assign bus_b.ReadEnable  = d_re[1];
  assign bus_b.ReadBurst   = d_rb[1];
  assign bus_b.ReadAddr    = d_raddr[1][4:0];
  assign bus_b.WriteEnable = d_we[1];
  assign bus_b.WriteAddr   = d_waddr[1][2:0];
  assign bus_b.WriteBE     = d_wbe[1];
  assign bus_b.WriteData   = d_wdata[1];

  logic        o_rdy [2];
  logic        o_vld [2];
  logic [31:0] o_dat [2];
  assign o_rdy[0] = bus_a.ReadReady;
  assign o_vld[0] = bus_a.ReadValid;
  assign o_dat[0] = bus_a.ReadData;
  assign o_rdy[1] = bus_b.ReadReady;
  assign o_vld[1] = bus_b.ReadValid;
  assign o_dat[1] = bus_b.ReadData;

  // Reference model state: byte image of each file, pending lane addresses, expected outputs.
  logic [7:0]  mem     [2][32][16];
  int          pq      [2][4];
  int          pn      [2];
  logic        exp_vld [2];
  logic [31:0] exp_dat [2];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int nl(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int nrows(input int k);
    return (k == 0) ? 32 : 8;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Lane a (flat {row,lane} index) as seen by a read this cycle.
  function automatic logic [31:0] ref_lane(input int k, input int a);
    int n, row, lane, b;
    logic [31:0] v;
`ifdef RF_READ_BYPASS_EN
    int wr;
    wr = int'(d_waddr[k]) % nrows(k);
`endif
    n = nl(k);
    row = a / n;
    lane = a % n;
    for (int j = 0; j < 4; j++) begin
      b = lane * 4 + j;
      v[8*j +: 8] = mem[k][row][b];
`ifdef RF_READ_BYPASS_EN
      if (d_we[k] && wr == row && d_wbe[k][b]) v[8*j +: 8] = d_wdata[k][8*b +: 8];
`endif
    end
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step(input int k);
    int n, rows, ra, wr;
    n = nl(k);
    rows = nrows(k);
    wr = int'(d_waddr[k]) % rows;
    if (!rst_n) begin
      pn[k] = 0;
      exp_vld[k] = 1'b0;
      exp_dat[k] = '0;
    end else begin
      if (pn[k] == 0 && d_re[k]) begin
        ra = int'(d_raddr[k]) % (rows * n);
        if (d_rb[k]) begin
          for (int i = 0; i < n; i++) pq[k][i] = (ra / n) * n + ((ra % n) + i) % n;
          pn[k] = n;
        end else begin
          pq[k][0] = ra;
          pn[k] = 1;
        end
      end
      if (pn[k] > 0) begin
        exp_vld[k] = 1'b1;
        exp_dat[k] = ref_lane(k, pq[k][0]);
        for (int i = 0; i < 3; i++) pq[k][i] = pq[k][i+1];
        pn[k]--;
      end else begin
        exp_vld[k] = 1'b0;
      end
    end
    if (d_we[k]) begin
      for (int b = 0; b < 4 * n; b++) begin
        if (d_wbe[k][b]) mem[k][wr][b] = d_wdata[k][8*b +: 8];
      end
    end
  endtask

  // Inputs are set at a negedge; step the model, clock once, compare at the next negedge.
  task automatic tick();
    string nm;
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      nm = (k == 0) ? "A" : "B";
      check_val({nm, ".ReadReady"}, o_rdy[k], (pn[k] == 0));
      check_val({nm, ".ReadValid"}, o_vld[k], exp_vld[k]);
      check_val({nm, ".ReadData"},  o_dat[k], exp_dat[k]);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      d_re[k] = 1'b0;  d_rb[k] = 1'b0;  d_raddr[k] = '0;
      d_we[k] = 1'b0;  d_waddr[k] = '0; d_wbe[k] = '0; d_wdata[k] = '0;
    end
  endtask

  task automatic set_rd(input int k, input logic en, input logic burst, input int addr);
    d_re[k] = en;
    d_rb[k] = burst;
    d_raddr[k] = 8'(addr);
  endtask

  task automatic set_wr(input int k, input int row, input logic [15:0] be, input logic [127:0] data);
    d_we[k] = 1'b1;
    d_waddr[k] = 8'(row);
    d_wbe[k] = be;
    d_wdata[k] = data;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_all();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pn[k] = 0; exp_vld[k] = 1'b0; exp_dat[k] = '0;
    end
    @(negedge clk);

    // Fill every row while reset is held: storage writes are not reset-gated.
    for (int r = 0; r < 32; r++) begin
      idle_all();
      set_wr(0, r, 16'h00FF, {$urandom, $urandom, $urandom, $urandom});
      if (r < 8) set_wr(1, r, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    rst_n = 1'b1;

    // A: full write then single reads of both lanes.
    idle_all(); set_wr(0, 3, 16'h00FF, 128'hDEAD_BEEF_0123_4567); tick();
    idle_all(); set_rd(0, 1, 0, 6); tick();
    check_val("A.rd6", o_dat[0], 32'h0123_4567);
    check_val("A.rd6_vld", o_vld[0], 1'b1);
    set_rd(0, 1, 0, 7); tick();
    check_val("A.rd7", o_dat[0], 32'hDEAD_BEEF);

    // A: partial write of the low lane only.
    idle_all(); set_wr(0, 3, 16'h000F, 128'h0); tick();
    idle_all(); set_rd(0, 1, 0, 6); tick();
    check_val("A.part_lo", o_dat[0], 32'h0);
    set_rd(0, 1, 0, 7); tick();
    check_val("A.part_hi", o_dat[0], 32'hDEAD_BEEF);

    // A: burst from lane 1 wraps to lane 0; a request in the busy cycle is dropped.
    idle_all(); set_rd(0, 1, 1, 7); tick();
    check_val("A.burst0", o_dat[0], 32'hDEAD_BEEF);
    check_val("A.burst_busy", o_rdy[0], 1'b0);
    set_rd(0, 1, 0, 6); tick();
    check_val("A.burst1", o_dat[0], 32'h0);
    check_val("A.burst_last_rdy", o_rdy[0], 1'b1);
    idle_all(); tick();
    check_val("A.dropped_req", o_vld[0], 1'b0);

    // A: same-cycle write and read of row 5.
    set_wr(0, 5, 16'h00FF, {128{1'b1}}); set_rd(0, 1, 0, 10); tick();
`ifdef RF_READ_BYPASS_EN
    check_val("A.bypass", o_dat[0], 32'hFFFF_FFFF);
`endif
    idle_all(); set_rd(0, 1, 0, 10); tick();
    check_val("A.after_wr", o_dat[0], 32'hFFFF_FFFF);

    // B: 4-lane burst from lane 2, then a back-to-back request on the last beat.
    idle_all(); set_wr(1, 2, 16'hFFFF, 128'h4444_4444_3333_3333_2222_2222_1111_1111); tick();
    idle_all(); set_rd(1, 1, 1, 10); tick();
    check_val("B.lane2", o_dat[1], 32'h3333_3333);
    idle_all(); tick();
    check_val("B.lane3", o_dat[1], 32'h4444_4444);
    tick();
    check_val("B.lane0", o_dat[1], 32'h1111_1111);
    tick();
    check_val("B.lane1", o_dat[1], 32'h2222_2222);
    check_val("B.last_rdy", o_rdy[1], 1'b1);
    set_rd(1, 1, 0, 10); tick();
    check_val("B.b2b_vld", o_vld[1], 1'b1);
    check_val("B.b2b_dat", o_dat[1], 32'h3333_3333);

    // B: reset while beat 2 of a burst is on the output.
    idle_all(); set_rd(1, 1, 1, 8); tick();
    idle_all(); tick();
    rst_n = 1'b0; tick();
    check_val("B.rst_vld", o_vld[1], 1'b0);
    check_val("B.rst_rdy", o_rdy[1], 1'b1);
    check_val("B.rst_dat", o_dat[1], 32'h0);
    rst_n = 1'b1; set_rd(1, 1, 0, 11); tick();
    check_val("B.kept", o_dat[1], 32'h4444_4444);
    idle_all(); tick();
    check_val("B.no_more_beats", o_vld[1], 1'b0);

    // Randomized traffic on both configurations.
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int k = 0; k < 2; k++) begin
        d_re[k]    = ($urandom_range(0, 2) != 0);
        d_rb[k]    = 1'($urandom_range(0, 1));
        d_raddr[k] = 8'($urandom);
        d_we[k]    = 1'($urandom_range(0, 1));
        d_waddr[k] = 8'($urandom);
        d_wbe[k]   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        d_wdata[k] = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) d_waddr[k] = d_raddr[k] >> ((k == 0) ? 1 : 2);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
